regfile_dump_reader: RTL and testbench

//  Debug/scan engine on the other end of a regfile read port: on start, walks register addresses

---
 rtl/regfile_dump_reader_pkg.sv | 19 +
 rtl/regfile_dump_reader.sv | 129 ++++++++++++
 tb/tb_regfile_dump_reader.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// Shared regfile bus widths and dump-engine state encoding.
// Anything that connects to the regfile read port imports this package.
package regfile_dump_reader_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;
    localparam int REG_NUM    = 32;

    typedef logic [REG_W-1:0]      reg_bus_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks FIRST_ADDR..LAST_ADDR through a shared regfile read port and streams {addr,data}
// words out. The engine keeps a running XOR checksum of every word it streams.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 31
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    input  logic      abort,
    output logic      busy,
    output logic      done,
    output reg_bus_t  checksum,
    input  logic      port_grant,
    output logic      re,
    output reg_addr_t raddr,
    input  reg_bus_t  rdata,
    output logic      out_valid,
    input  logic      out_ready,
    output reg_addr_t out_addr,
    output reg_bus_t  out_data,
    output state_t    dbg_state
);

    // Output handshake: a word transfers on any rising edge where out_valid && out_ready;
    // out_valid never drops and out_addr/out_data never change until that transfer, except on abort or rst.

    if (FIRST_ADDR < 0 || FIRST_ADDR > LAST_ADDR || LAST_ADDR >= REG_NUM) begin : g_bad_range
        $error("regfile_dump_reader: FIRST_ADDR/LAST_ADDR range is illegal");
    end

    localparam reg_addr_t FIRST = reg_addr_t'(FIRST_ADDR);
    localparam reg_addr_t LAST  = reg_addr_t'(LAST_ADDR);

    state_t    state;
    state_t    state_next;
    reg_addr_t addr_cnt;
    logic      launch;
    logic      capture;
    logic      accept;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The ID stage owns the read port whenever port_grant is low, so re follows grant directly.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        re         = 1'b0;
        raddr      = '0;
        launch     = 1'b0;
        capture    = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start && !abort) begin
                    launch     = 1'b1;
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                raddr = addr_cnt;
                re    = port_grant;
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (port_grant) begin
                    capture    = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (out_ready) begin
                    accept     = 1'b1;
                    state_next = (addr_cnt == LAST) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The counter stops at LAST rather than incrementing, so LAST=31 never wraps to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt  <= FIRST;
            checksum  <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            if (launch) begin
                addr_cnt <= FIRST;
                checksum <= '0;
            end
            if (capture) begin
                out_data  <= rdata;
                out_addr  <= addr_cnt;
                checksum  <= checksum ^ rdata;
                out_valid <= 1'b1;
            end
            if (accept) begin
                out_valid <= 1'b0;
                if (addr_cnt != LAST) begin
                    addr_cnt <= addr_cnt + 5'd1;
                end
            end
            if (abort && state != ST_IDLE) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: two instances (full 0..31 range and a 30..31 range) on a
// behavioural regfile with same-cycle write forwarding, checked against a word-list model.
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] regs [32];
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    logic a_start, a_abort, a_grant, a_ready, a_busy, a_done, a_re, a_out_valid;
    logic [31:0] a_checksum, a_rdata, a_out_data;
    logic [4:0]  a_raddr, a_out_addr;
    state_t      a_state;

    logic b_start, b_abort, b_grant, b_ready, b_busy, b_done, b_re, b_out_valid;
    logic [31:0] b_checksum, b_rdata, b_out_data;
    logic [4:0]  b_raddr, b_out_addr;
    state_t      b_state;

    logic [36:0] exp_q_a [$];
    logic [36:0] exp_q_b [$];
    logic [31:0] a_exp_sum, b_exp_sum;
    int          a_done_cnt = 0;
    int          b_done_cnt = 0;

    // Regfile model: address 0 reads as zero, a same-cycle write is forwarded.
    assign a_rdata = (!a_re || a_raddr == 5'd0) ? 32'd0 :
                     (we && waddr == a_raddr) ? wdata : regs[a_raddr];
    assign b_rdata = (!b_re || b_raddr == 5'd0) ? 32'd0 :
                     (we && waddr == b_raddr) ? wdata : regs[b_raddr];

    regfile_dump_reader #(.FIRST_ADDR(0), .LAST_ADDR(31)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .busy(a_busy), .done(a_done),
        .checksum(a_checksum), .port_grant(a_grant), .re(a_re), .raddr(a_raddr), .rdata(a_rdata),
        .out_valid(a_out_valid), .out_ready(a_ready), .out_addr(a_out_addr), .out_data(a_out_data),
        .dbg_state(a_state)
    );

    regfile_dump_reader #(.FIRST_ADDR(30), .LAST_ADDR(31)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .busy(b_busy), .done(b_done),
        .checksum(b_checksum), .port_grant(b_grant), .re(b_re), .raddr(b_raddr), .rdata(b_rdata),
        .out_valid(b_out_valid), .out_ready(b_ready), .out_addr(b_out_addr), .out_data(b_out_data),
        .dbg_state(b_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_regs(input bit random_fill);
        for (int i = 0; i < 32; i++) begin
            regs[i] = random_fill ? $urandom : 32'(i) * 32'h0101_0101;
        end
        regs[0] = 32'd0;
    endtask

    // Reference model: the dump is simply the list of (addr, contents) pairs, in order.
    task automatic expect_dump(input bit sel_b, input int first, input int last,
                               input bit ov_en, input int ov_addr, input logic [31:0] ov_data);
        logic [31:0] d;
        logic [31:0] sum;
        sum = 32'd0;
        for (int i = first; i <= last; i++) begin
            d = (i == 0) ? 32'd0 : regs[i];
            if (ov_en && ov_addr == i) d = ov_data;
            sum = sum ^ d;
            if (sel_b) exp_q_b.push_back({5'(i), d});
            else       exp_q_a.push_back({5'(i), d});
        end
        if (sel_b) b_exp_sum = sum;
        else       a_exp_sum = sum;
    endtask

    task automatic monitor();
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if ((a_re && !a_grant) || (b_re && !b_grant)) begin
                    errors++;
                    $display("FAIL re_without_grant a_re=%b a_grant=%b b_re=%b b_grant=%b expected re=0 without grant",
                             a_re, a_grant, b_re, b_grant);
                end
                if (a_out_valid && a_ready) begin
                    checks++;
                    if (exp_q_a.size() == 0) begin
                        errors++;
                        $display("FAIL a_word_unexpected got addr=%0d data=%h expected no word", a_out_addr, a_out_data);
                    end else begin
                        e = exp_q_a.pop_front();
                        if ({a_out_addr, a_out_data} !== e) begin
                            errors++;
                            $display("FAIL a_word got addr=%0d data=%h expected addr=%0d data=%h",
                                     a_out_addr, a_out_data, e[36:32], e[31:0]);
                        end
                    end
                end
                if (b_out_valid && b_ready) begin
                    checks++;
                    if (exp_q_b.size() == 0) begin
                        errors++;
                        $display("FAIL b_word_unexpected got addr=%0d data=%h expected no word", b_out_addr, b_out_data);
                    end else begin
                        e = exp_q_b.pop_front();
                        if ({b_out_addr, b_out_data} !== e) begin
                            errors++;
                            $display("FAIL b_word got addr=%0d data=%h expected addr=%0d data=%h",
                                     b_out_addr, b_out_data, e[36:32], e[31:0]);
                        end
                    end
                end
                if (a_done) begin
                    a_done_cnt++;
                    checks++;
                    if (a_checksum !== a_exp_sum) begin
                        errors++;
                        $display("FAIL a_checksum got %h expected %h", a_checksum, a_exp_sum);
                    end
                end
                if (b_done) begin
                    b_done_cnt++;
                    checks++;
                    if (b_checksum !== b_exp_sum) begin
                        errors++;
                        $display("FAIL b_checksum got %h expected %h", b_checksum, b_exp_sum);
                    end
                end
            end
        end
    endtask

    task automatic wait_done_a(input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (a_done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL a_done_timeout got no done expected done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({a_busy, a_done, a_re, a_out_valid, a_raddr, a_out_addr, a_out_data, a_checksum} !== 75'd0
            || a_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_a busy=%b done=%b re=%b valid=%b raddr=%0d oaddr=%0d odata=%h sum=%h expected all zero",
                     a_busy, a_done, a_re, a_out_valid, a_raddr, a_out_addr, a_out_data, a_checksum);
        end
        checks++;
        if ({b_busy, b_done, b_re, b_out_valid, b_raddr, b_out_addr, b_out_data, b_checksum} !== 75'd0
            || b_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_b busy=%b done=%b re=%b valid=%b expected all zero", b_busy, b_done, b_re, b_out_valid);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset a_busy=%b b_busy=%b expected 0", a_busy, b_busy);
        end
    endtask

    task automatic test_full_dump();
        int d0;
        load_regs(1'b0);
        a_grant = 1'b1;
        a_ready = 1'b1;
        expect_dump(1'b0, 0, 31, 1'b0, 0, 32'd0);
        d0 = a_done_cnt;
        tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_re !== 1'b1 || a_raddr !== 5'd0) begin
            errors++;
            $display("FAIL first_read got valid=%b re=%b raddr=%0d expected valid=0 re=1 raddr=0", a_out_valid, a_re, a_raddr);
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_addr !== 5'd0) begin
            errors++;
            $display("FAIL first_word_latency got valid=%b addr=%0d expected valid=1 addr=0", a_out_valid, a_out_addr);
        end
        wait_done_a(200);
        tick();
        checks++;
        if (a_done_cnt !== d0 + 1 || exp_q_a.size() != 0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL full_dump_end got done_cnt=%0d left=%0d busy=%b expected done_cnt=%0d left=0 busy=0",
                     a_done_cnt, exp_q_a.size(), a_busy, d0 + 1);
        end
    endtask

    task automatic test_grant_stall();
        int low;
        bit seen;
        load_regs(1'b1);
        a_grant = 1'b1;
        a_ready = 1'b1;
        low  = 0;
        seen = 1'b0;
        expect_dump(1'b0, 0, 31, 1'b0, 0, 32'd0);
        tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            tick();
            if (a_raddr == 5'd5 && low < 3) begin
                a_grant = 1'b0;
                low++;
                #1;
                checks++;
                if (a_re !== 1'b0 || a_raddr !== 5'd5) begin
                    errors++;
                    $display("FAIL grant_stall got re=%b raddr=%0d expected re=0 raddr=5", a_re, a_raddr);
                end
            end else begin
                a_grant = 1'b1;
            end
            @(negedge clk);
            if (a_done) seen = 1'b1;
        end
        checks++;
        if (!seen || low != 3 || exp_q_a.size() != 0) begin
            errors++;
            $display("FAIL grant_stall_end got done=%b stalls=%0d left=%0d expected done=1 stalls=3 left=0",
                     seen, low, exp_q_a.size());
        end
    endtask

    task automatic test_ready_stall();
        int low;
        bit seen;
        load_regs(1'b1);
        a_grant = 1'b1;
        a_ready = 1'b1;
        low  = 0;
        seen = 1'b0;
        expect_dump(1'b0, 0, 31, 1'b0, 0, 32'd0);
        tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            tick();
            if (a_out_valid && a_out_addr == 5'd7 && low < 4) begin
                a_ready = 1'b0;
                low++;
                #1;
                checks++;
                if (a_out_valid !== 1'b1 || a_out_addr !== 5'd7 || a_out_data !== regs[7] || a_re !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_stall got valid=%b addr=%0d data=%h re=%b expected valid=1 addr=7 data=%h re=0",
                             a_out_valid, a_out_addr, a_out_data, a_re, regs[7]);
                end
            end else begin
                a_ready = 1'b1;
            end
            @(negedge clk);
            if (a_done) seen = 1'b1;
        end
        checks++;
        if (!seen || low != 4 || exp_q_a.size() != 0) begin
            errors++;
            $display("FAIL ready_stall_end got done=%b stalls=%0d left=%0d expected done=1 stalls=4 left=0",
                     seen, low, exp_q_a.size());
        end
    endtask

    task automatic test_write_forward();
        bit wrote;
        load_regs(1'b1);
        a_grant = 1'b1;
        a_ready = 1'b1;
        wrote   = 1'b0;
        expect_dump(1'b0, 0, 31, 1'b1, 9, 32'hDEAD_BEEF);
        tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 0; c < 200 && !wrote; c++) begin
            tick();
            if (a_raddr == 5'd9) begin
                we    = 1'b1;
                waddr = 5'd9;
                wdata = 32'hDEAD_BEEF;
                wrote = 1'b1;
            end
        end
        tick();
        if (we) regs[9] = 32'hDEAD_BEEF;
        we = 1'b0;
        wait_done_a(200);
        tick();
        checks++;
        if (!wrote || exp_q_a.size() != 0) begin
            errors++;
            $display("FAIL write_forward_end got wrote=%b left=%0d expected wrote=1 left=0", wrote, exp_q_a.size());
        end
    endtask

    task automatic test_abort();
        bit aborted;
        int d0;
        logic [31:0] partial;
        load_regs(1'b1);
        a_grant = 1'b1;
        a_ready = 1'b1;
        aborted = 1'b0;
        d0      = a_done_cnt;
        partial = 32'd0;
        for (int i = 0; i <= 12; i++) partial = partial ^ regs[i];
        expect_dump(1'b0, 0, 31, 1'b0, 0, 32'd0);
        tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 0; c < 200 && !aborted; c++) begin
            tick();
            if (a_out_valid && a_out_addr == 5'd12) begin
                a_ready = 1'b0;
                a_abort = 1'b1;
                aborted = 1'b1;
            end
        end
        tick();
        a_abort = 1'b0;
        a_ready = 1'b1;
        checks++;
        if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_re !== 1'b0 || a_state !== ST_IDLE) begin
            errors++;
            $display("FAIL abort_idle got busy=%b valid=%b re=%b expected busy=0 valid=0 re=0", a_busy, a_out_valid, a_re);
        end
        repeat (4) tick();
        checks++;
        if (!aborted || exp_q_a.size() != 20 || a_done_cnt !== d0 || a_checksum !== partial) begin
            errors++;
            $display("FAIL abort_state got left=%0d done_cnt=%0d sum=%h expected left=20 done_cnt=%0d sum=%h",
                     exp_q_a.size(), a_done_cnt, a_checksum, d0, partial);
        end
        exp_q_a.delete();
        a_start = 1'b1;
        a_abort = 1'b1;
        tick();
        a_start = 1'b0;
        a_abort = 1'b0;
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_same_cycle got busy=%b expected 0", a_busy);
        end
        expect_dump(1'b0, 0, 31, 1'b0, 0, 32'd0);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_addr !== 5'd0) begin
            errors++;
            $display("FAIL restart_first got valid=%b addr=%0d expected valid=1 addr=0", a_out_valid, a_out_addr);
        end
        wait_done_a(200);
        tick();
        checks++;
        if (exp_q_a.size() != 0 || a_done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL restart_end got left=%0d done_cnt=%0d expected left=0 done_cnt=%0d",
                     exp_q_a.size(), a_done_cnt, d0 + 1);
        end
    endtask

    task automatic test_rst_mid_dump();
        bit hit;
        bit seen;
        int d0;
        load_regs(1'b1);
        b_grant = 1'b1;
        b_ready = 1'b1;
        hit     = 1'b0;
        expect_dump(1'b1, 30, 31, 1'b0, 0, 32'd0);
        tick();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            tick();
            if (b_out_valid && b_out_addr == 5'd30) begin
                b_ready = 1'b0;
                rst     = 1'b1;
                hit     = 1'b1;
            end
        end
        tick();
        checks++;
        if (!hit || {b_busy, b_done, b_re, b_out_valid, b_raddr, b_out_addr, b_out_data, b_checksum} !== 75'd0
            || b_state !== ST_IDLE) begin
            errors++;
            $display("FAIL rst_mid_dump got hit=%b busy=%b valid=%b oaddr=%0d odata=%h sum=%h expected all zero",
                     hit, b_busy, b_out_valid, b_out_addr, b_out_data, b_checksum);
        end
        rst     = 1'b0;
        b_ready = 1'b1;
        exp_q_b.delete();
        d0 = b_done_cnt;
        expect_dump(1'b1, 30, 31, 1'b0, 0, 32'd0);
        tick();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (b_done) seen = 1'b1;
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (b_re !== 1'b0 || b_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b_no_wrap got re=%b valid=%b raddr=%0d expected re=0 valid=0", b_re, b_out_valid, b_raddr);
            end
        end
        checks++;
        if (!seen || exp_q_b.size() != 0 || b_done_cnt !== d0 + 1 || b_checksum !== (regs[30] ^ regs[31])) begin
            errors++;
            $display("FAIL b_two_words got done=%b left=%0d done_cnt=%0d sum=%h expected done=1 left=0 done_cnt=%0d sum=%h",
                     seen, exp_q_b.size(), b_done_cnt, b_checksum, d0 + 1, regs[30] ^ regs[31]);
        end
    endtask

    task automatic test_random_backpressure();
        bit seen;
        int d0;
        for (int r = 0; r < 3; r++) begin
            load_regs(1'b1);
            expect_dump(1'b0, 0, 31, 1'b0, 0, 32'd0);
            d0   = a_done_cnt;
            seen = 1'b0;
            for (int c = 0; c < 1000 && !seen; c++) begin
                tick();
                a_grant = ($urandom_range(0, 3) != 0);
                a_ready = ($urandom_range(0, 3) != 0);
                a_start = (c == 0 || c == 20 + r);
                @(negedge clk);
                if (a_done) seen = 1'b1;
            end
            a_start = 1'b0;
            tick();
            checks++;
            if (!seen || exp_q_a.size() != 0 || a_done_cnt !== d0 + 1) begin
                errors++;
                $display("FAIL random_dump got done=%b left=%0d done_cnt=%0d expected done=1 left=0 done_cnt=%0d",
                         seen, exp_q_a.size(), a_done_cnt, d0 + 1);
            end
        end
        a_grant = 1'b1;
        a_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        we = 1'b0; waddr = 5'd0; wdata = 32'd0;
        a_start = 1'b0; a_abort = 1'b0; a_grant = 1'b0; a_ready = 1'b0;
        b_start = 1'b0; b_abort = 1'b0; b_grant = 1'b0; b_ready = 1'b0;
        a_exp_sum = 32'd0;
        b_exp_sum = 32'd0;
        load_regs(1'b0);
        fork
            monitor();
        join_none
        test_reset();
        test_full_dump();
        test_grant_stall();
        test_ready_stall();
        test_write_forward();
        test_abort();
        test_rst_mid_dump();
        test_random_backpressure();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
